// File: rtl/phy_tx_pkg.sv
// Shared constants, widths and state/load-source encodings for the PHY TX serializer.
package phy_tx_pkg;

  localparam logic [7:0]  COM_DEF         = 8'hBC;
  localparam int unsigned TRAIN_COUNT_DEF = 4;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned PTR_W       = 2;
  localparam int unsigned CNT_W       = 3;
  localparam int unsigned BIT_CNT_W   = 3;
  localparam int unsigned TRAIN_CNT_W = 8;

  typedef enum logic [0:0] {
    ST_TRAIN  = 1'b0,
    ST_ACTIVE = 1'b1
  } tx_state_e;

  // What the shift register takes on a load edge; SRC_NONE means plain shift.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_COM  = 2'd1,
    SRC_FIFO = 2'd2
  } ld_src_e;

  // Pointer advance; the power-of-two width gives the 3->0 wrap for free.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/sync_fifo4.sv
// Four-entry byte FIFO with registered occupancy flags; simultaneous write and pop
// are both honoured even when full.
module sync_fifo4
  import phy_tx_pkg::*;
(
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [BYTE_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [BYTE_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_full;
  logic              r_empty;

  logic              w_pop;
  logic              w_push;
  logic [CNT_W-1:0]  w_count_next;

  // A pop frees the slot the write lands in, so a full FIFO still accepts a write alongside it.
  assign w_pop  = rd_en && !r_empty;
  assign w_push = wr_en && (!r_full || w_pop);

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= w_count_next;
      r_full  <= (w_count_next == CNT_W'(FIFO_DEPTH));
      r_empty <= (w_count_next == CNT_W'(0));
    end
  end

  // Storage needs no reset: the pointers decide what is valid.
  always_ff @(posedge clk_32f) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;
  assign full    = r_full;
  assign empty   = r_empty;

endmodule

// File: rtl/serializer_tx.sv
// Byte-to-bit serializer: sends TRAIN_COUNT COM symbols after reset, then FIFO data
// MSB first, filling gaps with COM. One byte slot every 8 clocks.
module serializer_tx
  import phy_tx_pkg::*;
#(
  parameter int unsigned TRAIN_COUNT = TRAIN_COUNT_DEF,
  parameter logic [7:0]  COM         = COM_DEF
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              valid_in,
  output logic              data_out,
  output logic              frame_sync,
  output logic              active,
  output logic              fifo_empty,
  output logic              overflow
);

  tx_state_e              r_state;
  tx_state_e              w_state_next;
  ld_src_e                w_ld_src;
  logic                   w_pop;
  logic                   w_train_inc;

  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic [TRAIN_CNT_W-1:0] r_train_cnt;
  logic [BYTE_W-1:0]      r_sr;
  logic                   r_frame_sync;
  logic                   r_active;
  logic                   r_overflow;
  logic                   w_load;

  logic [BYTE_W-1:0]      w_fifo_rd_data;
  logic [CNT_W-1:0]       w_fifo_count;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;

  sync_fifo4 u_fifo (
    .clk_32f (clk_32f),
    .reset   (reset),
    .wr_en   (valid_in),
    .wr_data (data_in),
    .rd_en   (w_pop),
    .rd_data (w_fifo_rd_data),
    .count   (w_fifo_count),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty)
  );

  assign w_load = (r_bit_cnt == BIT_CNT_W'(7));

  always_ff @(posedge clk_32f) begin
    if (reset) r_state <= ST_TRAIN;
    else       r_state <= w_state_next;
  end

  // Next state plus the load-source decision for the current byte slot.
  always_comb begin
    w_state_next = r_state;
    w_ld_src     = SRC_NONE;
    w_pop        = 1'b0;
    w_train_inc  = 1'b0;
    case (r_state)
      ST_TRAIN: begin
        if (w_load) begin
          w_ld_src    = SRC_COM;
          w_train_inc = 1'b1;
          if (r_train_cnt == TRAIN_CNT_W'(TRAIN_COUNT - 1)) w_state_next = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (w_load) begin
          if (w_fifo_count != CNT_W'(0)) begin
            w_ld_src = SRC_FIFO;
            w_pop    = 1'b1;
          end else begin
            w_ld_src = SRC_COM;
          end
        end
      end
      default: w_state_next = ST_TRAIN;
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_bit_cnt    <= '0;
      r_train_cnt  <= '0;
      r_sr         <= '0;
      r_frame_sync <= 1'b0;
      r_active     <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_bit_cnt    <= r_bit_cnt + BIT_CNT_W'(1);
      if (w_train_inc) r_train_cnt <= r_train_cnt + TRAIN_CNT_W'(1);
      case (w_ld_src)
        SRC_COM:  r_sr <= COM;
        SRC_FIFO: r_sr <= w_fifo_rd_data;
        default:  r_sr <= {r_sr[BYTE_W-2:0], 1'b0};
      endcase
      r_frame_sync <= w_load;
      r_active     <= (w_state_next == ST_ACTIVE);
      // Dropped only when full and no pop frees a slot this cycle.
      if (valid_in && w_fifo_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign data_out   = r_sr[BYTE_W-1];
  assign frame_sync = r_frame_sync;
  assign active     = r_active;
  assign fifo_empty = w_fifo_empty;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_serializer_tx.sv
// Directed bench for serializer_tx: per-edge write/flag vectors and a per-byte-slot
// expected stream, plus a hand-written mid-byte reset sequence.
module tb_serializer_tx;

  logic       clk_32f;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       data_out;
  logic       frame_sync;
  logic       active;
  logic       fifo_empty;
  logic       overflow;

  serializer_tx dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .data_out   (data_out),
    .frame_sync (frame_sync),
    .active     (active),
    .fifo_empty (fifo_empty),
    .overflow   (overflow)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  typedef struct {
    int         edge_n;
    logic       wr;
    logic [7:0] d;
    logic       chk;
    logic       act;
    logic       emp;
    logic       ovf;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_frame [0:31];
  int         n_cmp;
  int         n_err;

  function automatic vec_t mk(input int e, input logic wr, input logic [7:0] d,
                              input logic chk, input logic act, input logic emp,
                              input logic ovf);
    vec_t v;
    v.edge_n = e; v.wr = wr; v.d = d; v.chk = chk; v.act = act; v.emp = emp; v.ovf = ovf;
    return v;
  endfunction

  task automatic check(input string name, input int e, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %b want %b", name, e, got, want);
    end
  endtask

  // Edge e counts rising edges after reset release; slot f starts at edge 8*f.
  task automatic run_scenario(input int n_edges);
    logic [7:0] fb;
    logic       exp_bit;
    for (int e = 1; e <= n_edges; e++) begin
      valid_in = 1'b0;
      data_in  = 8'h00;
      foreach (vecs[k]) begin
        if (vecs[k].edge_n == e && vecs[k].wr) begin
          valid_in = 1'b1;
          data_in  = vecs[k].d;
        end
      end
      @(posedge clk_32f);
      #1;
      fb      = exp_frame[5'(e / 8)];
      exp_bit = (e < 8) ? 1'b0 : fb[3'(7 - (e % 8))];
      check("data_out", e, data_out, exp_bit);
      check("frame_sync", e, frame_sync, (e >= 8) && (e % 8 == 0));
      foreach (vecs[k]) begin
        if (vecs[k].edge_n == e && vecs[k].chk) begin
          check("active", e, active, vecs[k].act);
          check("fifo_empty", e, fifo_empty, vecs[k].emp);
          check("overflow", e, overflow, vecs[k].ovf);
        end
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic check_reset_state(input int tag);
    check("rst_data_out", tag, data_out, 1'b0);
    check("rst_frame_sync", tag, frame_sync, 1'b0);
    check("rst_active", tag, active, 1'b0);
    check("rst_fifo_empty", tag, fifo_empty, 1'b1);
    check("rst_overflow", tag, overflow, 1'b0);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    repeat (3) @(posedge clk_32f);
    #1;
    check_reset_state(0);
    reset = 1'b0;

    // Scenario 1: training with bytes buffered, single byte, full-FIFO write on load, overflow.
    for (int i = 0; i < 32; i++) exp_frame[i] = 8'hBC;
    exp_frame[5]  = 8'h01; exp_frame[6]  = 8'h02; exp_frame[7]  = 8'h03; exp_frame[8]  = 8'h04;
    exp_frame[10] = 8'hA5;
    exp_frame[11] = 8'h66; exp_frame[12] = 8'h77; exp_frame[13] = 8'h88; exp_frame[14] = 8'h99;
    exp_frame[15] = 8'hAA;
    exp_frame[17] = 8'h11; exp_frame[18] = 8'h22; exp_frame[19] = 8'h33; exp_frame[20] = 8'h44;

    vecs.delete();
    vecs.push_back(mk(1,   1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(2,   1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(3,   1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(4,   1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(5,   1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(31,  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32,  1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(64,  1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(75,  1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(80,  1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(81,  1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(82,  1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(83,  1'b1, 8'h88, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(84,  1'b1, 8'h99, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(88,  1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(120, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(129, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(130, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(131, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(132, 1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(133, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(159, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(160, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mk(169, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(170, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1));
    run_scenario(170);

    // Mid-byte reset with two bytes queued: everything cleared at the reset edge.
    reset    = 1'b1;
    valid_in = 1'b0;
    @(posedge clk_32f);
    #1;
    check_reset_state(1);
    reset = 1'b0;

    // Scenario 2: training restarts from zero, queued bytes never appear, COM forever.
    for (int i = 0; i < 32; i++) exp_frame[i] = 8'hBC;
    vecs.delete();
    vecs.push_back(mk(1,  1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(31, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(32, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(47, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0));
    run_scenario(47);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
